channel_capture_bank: RTL and testbench
=======================================

CHANNEL_CAPTURE_BANK -- requirements
Module: channel_capture_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each captured word.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_wr_valid, input, 1, write request.
REQ-005 SHALL have port i_wr_sel, input, 3, target channel 0..7.
REQ-006 SHALL have port i_wr_data, input, DATA_W, write word.
REQ-007 SHALL have port o_wr_ready, output, 1, write accepted when high with i_wr_valid.
REQ-008 SHALL have port i_drain, input, 1, drain-sweep start request.
REQ-009 SHALL have port o_rd_valid, output, 1, read word presented.
REQ-010 SHALL have port i_rd_ready, input, 1, consumer accepts read word.
REQ-011 SHALL have port o_rd_data, output, DATA_W, presented word.
REQ-012 SHALL have port o_rd_ch, output, 3, channel index of presented word.
REQ-013 SHALL have port o_occ_mask, output, 8, per-channel occupied flags, bit n = channel n.
REQ-014 SHALL have port o_overwrite, output, 1, one-cycle pulse when a write hits an occupied channel.
REQ-015 SHALL have port o_done, output, 1, one-cycle pulse when a drain sweep completes.

Function
REQ-016 SHALL hold 8 DATA_W-bit slot registers plus the 8-bit occupied mask.
REQ-017 SHALL use FSM states IDLE, SCAN, OUT, with a 3-bit scan pointer.
REQ-018 SHALL drive o_wr_ready = 1 only in IDLE.
REQ-019 SHALL, on a write handshake, store i_wr_data into slot[i_wr_sel] and set occ bit i_wr_sel, both visible the next cycle.
REQ-020 SHALL, on a write to an occupied slot, overwrite the data and pulse o_overwrite the next cycle.
REQ-021 SHALL leave slot data unchanged when a write is not accepted.
REQ-022 SHALL, on i_drain high in IDLE, go to SCAN with pointer = 0; i_drain SHALL be ignored in SCAN and OUT.
REQ-023 SHALL, when i_wr_valid and i_drain are both high in IDLE, accept the write, start the drain, and include the new word in the sweep.
REQ-024 SHALL, in SCAN, examine one channel per cycle: if occ[ptr] = 1, load o_rd_data = slot[ptr] and o_rd_ch = ptr, then go to OUT; otherwise, if ptr = 7, go to IDLE and pulse o_done, else increment ptr.
REQ-025 SHALL, in OUT, hold o_rd_valid = 1 and hold o_rd_data and o_rd_ch stable until i_rd_ready = 1.
REQ-026 SHALL, on the OUT handshake, clear occ[ptr]; if ptr = 7, go to IDLE and pulse o_done, else increment ptr and go to SCAN.
REQ-027 SHALL emit words in ascending channel order, with no wrap-around and each occupied channel exactly once per sweep.
REQ-028 SHALL deliver latency as follows: i_drain in cycle t with ch0 occupied gives o_rd_valid high in cycle t+2.
REQ-029 SHALL complete a drain of an all-empty bank with o_done pulsing 9 cycles after i_drain.
REQ-030 SHALL drive o_rd_valid = 0 outside OUT.

Reset
REQ-031 SHALL, on i_rst high at any time including mid-sweep, immediately force: state IDLE, ptr 0, o_occ_mask 0, o_rd_valid 0, o_rd_data 0, o_rd_ch 0, o_overwrite 0, o_done 0, all slots 0.
REQ-032 SHALL drive o_wr_ready = 1 in the first cycle after reset release.

Verification
REQ-033 SHALL cover: write 0x1111 to ch2, 0x7777 to ch7, then drain with i_rd_ready = 1 -> words (ch2, 0x1111) then (ch7, 0x7777), o_done pulses, o_occ_mask = 0x00.
REQ-034 SHALL cover: write 0xAAAA then 0xBBBB to ch3 -> o_overwrite pulses once, o_occ_mask = 0x08, and the drain returns 0xBBBB.
REQ-035 SHALL cover: ch0 occupied, i_rd_ready held low 5 cycles -> o_rd_valid, o_rd_data and o_rd_ch stable all 5 cycles; o_wr_ready = 0 throughout.
REQ-036 SHALL cover: empty bank, i_drain in cycle t -> o_done in cycle t+9 and o_rd_valid never high.
REQ-037 SHALL cover: i_wr_valid (ch5, 0x5555) together with i_drain in IDLE -> the sweep outputs (ch5, 0x5555).
REQ-038 SHALL cover: i_rst asserted while in OUT on ch4 -> all outputs reset in the same cycle, o_occ_mask = 0, o_wr_ready = 1 after release.

Source files
------------

// File: rtl/channel_capture_bank.sv
// Eight-slot capture bank: channels are written individually and later
// drained in ascending channel order through a valid/ready read port.
module channel_capture_bank #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [2:0]        i_wr_sel,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_drain,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [2:0]        o_rd_ch,
    output logic [7:0]        o_occ_mask,
    output logic              o_overwrite,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        ptr;
    logic [2:0]        ptr_nxt;
    logic [DATA_W-1:0] slot [8];
    logic [7:0]        occ;
    logic              wr_fire;
    logic              rd_fire;
    logic              load_word;
    logic              done_nxt;

    assign o_wr_ready = (state == IDLE);
    assign o_rd_valid = (state == OUT);
    assign o_occ_mask = occ;
    assign wr_fire    = i_wr_valid && o_wr_ready;
    assign rd_fire    = (state == OUT) && i_rd_ready;

    // State and scan pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Sweep sequencing: one channel examined per SCAN cycle, stall in OUT until accepted.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load_word = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_drain) begin
                    state_nxt = SCAN;
                    ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (occ[ptr]) begin
                    load_word = 1'b1;
                    state_nxt = OUT;
                end else if (ptr == 3'd7) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    ptr_nxt = ptr + 3'd1;
                end
            end
            OUT: begin
                if (i_rd_ready) begin
                    if (ptr == 3'd7) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        ptr_nxt   = ptr + 3'd1;
                        state_nxt = SCAN;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Slot storage, occupancy flags, presented word and status pulses.
    // Writes only land in IDLE and reads only retire in OUT, so the two
    // occupancy updates never target the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot[i] <= '0;
            end
            occ         <= '0;
            o_rd_data   <= '0;
            o_rd_ch     <= '0;
            o_overwrite <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_overwrite <= wr_fire && occ[i_wr_sel];
            o_done      <= done_nxt;
            if (wr_fire) begin
                slot[i_wr_sel] <= i_wr_data;
                occ[i_wr_sel]  <= 1'b1;
            end
            if (rd_fire) begin
                occ[ptr] <= 1'b0;
            end
            if (load_word) begin
                o_rd_data <= slot[ptr];
                o_rd_ch   <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_channel_capture_bank.sv
// Directed bench for channel_capture_bank.
module tb_channel_capture_bank;

    logic        i_clk;
    logic        i_rst;
    logic        i_wr_valid;
    logic [2:0]  i_wr_sel;
    logic [15:0] i_wr_data;
    logic        o_wr_ready;
    logic        i_drain;
    logic        o_rd_valid;
    logic        i_rd_ready;
    logic [15:0] o_rd_data;
    logic [2:0]  o_rd_ch;
    logic [7:0]  o_occ_mask;
    logic        o_overwrite;
    logic        o_done;

    int total = 0;
    int bad   = 0;

    logic [2:0]  cap_ch   [8];
    logic [15:0] cap_data [8];
    int          cap_n;
    int          cap_cyc;
    bit          cap_done;

    channel_capture_bank #(.DATA_W(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_valid  (i_wr_valid),
        .i_wr_sel    (i_wr_sel),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .i_drain     (i_drain),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_ch     (o_rd_ch),
        .o_occ_mask  (o_occ_mask),
        .o_overwrite (o_overwrite),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one cycle; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [15:0] data);
        i_wr_valid = 1'b1;
        i_wr_sel   = sel;
        i_wr_data  = data;
        step();
        i_wr_valid = 1'b0;
    endtask

    // Start a drain (optionally with a simultaneous write) with i_rd_ready high and
    // record every presented word; cap_cyc is the cycle offset of o_done from i_drain.
    task automatic drain_collect(input bit with_wr, input logic [2:0] sel, input logic [15:0] data);
        cap_n      = 0;
        cap_done   = 1'b0;
        i_drain    = 1'b1;
        i_rd_ready = 1'b1;
        i_wr_valid = with_wr;
        i_wr_sel   = sel;
        i_wr_data  = data;
        step();
        i_drain    = 1'b0;
        i_wr_valid = 1'b0;
        cap_cyc    = 1;
        while (!cap_done && cap_cyc < 40) begin
            if (o_done) begin
                cap_done = 1'b1;
            end else begin
                if (o_rd_valid) begin
                    if (cap_n < 8) begin
                        cap_ch[cap_n]   = o_rd_ch;
                        cap_data[cap_n] = o_rd_data;
                    end
                    cap_n++;
                end
                step();
                cap_cyc++;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        total++; if (o_occ_mask !== 8'h00) begin bad++; $display("FAIL reset_occ got=%h exp=00", o_occ_mask); end
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid); end
        total++; if (o_rd_data !== 16'h0000 || o_rd_ch !== 3'd0) begin bad++; $display("FAIL reset_rd_word got=%0d/%h exp=0/0000", o_rd_ch, o_rd_data); end
        total++; if (o_overwrite !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", o_overwrite, o_done); end
        i_rst = 1'b0;
        step();
        total++; if (o_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", o_wr_ready); end
    endtask

    task automatic test_basic_drain();
        do_reset();
        do_write(3'd2, 16'h1111);
        total++; if (o_occ_mask !== 8'h04) begin bad++; $display("FAIL basic_occ1 got=%h exp=04", o_occ_mask); end
        total++; if (o_overwrite !== 1'b0) begin bad++; $display("FAIL basic_no_ovw got=%b exp=0", o_overwrite); end
        do_write(3'd7, 16'h7777);
        total++; if (o_occ_mask !== 8'h84) begin bad++; $display("FAIL basic_occ2 got=%h exp=84", o_occ_mask); end
        drain_collect(1'b0, 3'd0, 16'h0000);
        total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", cap_done); end
        total++; if (cap_cyc !== 11) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=11", cap_cyc); end
        total++; if (cap_n !== 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", cap_n); end
        total++; if (cap_ch[0] !== 3'd2 || cap_data[0] !== 16'h1111) begin bad++; $display("FAIL basic_word0 got=%0d/%h exp=2/1111", cap_ch[0], cap_data[0]); end
        total++; if (cap_ch[1] !== 3'd7 || cap_data[1] !== 16'h7777) begin bad++; $display("FAIL basic_word1 got=%0d/%h exp=7/7777", cap_ch[1], cap_data[1]); end
        total++; if (o_occ_mask !== 8'h00) begin bad++; $display("FAIL basic_occ_end got=%h exp=00", o_occ_mask); end
        total++; if (o_wr_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", o_wr_ready); end
    endtask

    task automatic test_overwrite();
        do_reset();
        do_write(3'd3, 16'hAAAA);
        total++; if (o_overwrite !== 1'b0) begin bad++; $display("FAIL ovw_first got=%b exp=0", o_overwrite); end
        do_write(3'd3, 16'hBBBB);
        total++; if (o_overwrite !== 1'b1) begin bad++; $display("FAIL ovw_pulse got=%b exp=1", o_overwrite); end
        step();
        total++; if (o_overwrite !== 1'b0) begin bad++; $display("FAIL ovw_single got=%b exp=0", o_overwrite); end
        total++; if (o_occ_mask !== 8'h08) begin bad++; $display("FAIL ovw_occ got=%h exp=08", o_occ_mask); end
        drain_collect(1'b0, 3'd0, 16'h0000);
        total++; if (cap_n !== 1 || cap_ch[0] !== 3'd3 || cap_data[0] !== 16'hBBBB) begin bad++; $display("FAIL ovw_drain got=%0d:%0d/%h exp=1:3/bbbb", cap_n, cap_ch[0], cap_data[0]); end
    endtask

    task automatic test_stall();
        do_reset();
        do_write(3'd0, 16'h1234);
        i_rd_ready = 1'b0;
        i_drain    = 1'b1;
        step();
        i_drain    = 1'b0;
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL stall_t1_valid got=%b exp=0", o_rd_valid); end
        step();
        // Rejected write attempted throughout the stall: must not disturb anything.
        i_wr_valid = 1'b1;
        i_wr_sel   = 3'd0;
        i_wr_data  = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== 16'h1234 || o_rd_ch !== 3'd0 || o_wr_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d got=v%b d%h c%0d r%b exp=v1 d1234 c0 r0", k, o_rd_valid, o_rd_data, o_rd_ch, o_wr_ready);
            end
            step();
        end
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b1;
        step();
        total++; if (o_occ_mask !== 8'h00 || o_rd_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%h/%b exp=00/0", o_occ_mask, o_rd_valid); end
        cap_done = 1'b0;
        for (int k = 0; k < 20 && !cap_done; k++) begin
            if (o_done) cap_done = 1'b1;
            else step();
        end
        total++; if (cap_done !== 1'b1 || o_occ_mask !== 8'h00) begin bad++; $display("FAIL stall_finish got=%b/%h exp=1/00", cap_done, o_occ_mask); end
    endtask

    task automatic test_empty_drain();
        do_reset();
        drain_collect(1'b0, 3'd0, 16'h0000);
        total++; if (cap_done !== 1'b1 || cap_cyc !== 9) begin bad++; $display("FAIL empty_done got=%b@%0d exp=1@9", cap_done, cap_cyc); end
        total++; if (cap_n !== 0) begin bad++; $display("FAIL empty_no_valid got=%0d exp=0", cap_n); end
        step();
        total++; if (o_done !== 1'b0 || o_wr_ready !== 1'b1) begin bad++; $display("FAIL empty_after got=%b/%b exp=0/1", o_done, o_wr_ready); end
    endtask

    task automatic test_write_with_drain();
        do_reset();
        drain_collect(1'b1, 3'd5, 16'h5555);
        total++; if (cap_n !== 1 || cap_ch[0] !== 3'd5 || cap_data[0] !== 16'h5555) begin bad++; $display("FAIL wrdrain_word got=%0d:%0d/%h exp=1:5/5555", cap_n, cap_ch[0], cap_data[0]); end
        total++; if (cap_done !== 1'b1 || o_occ_mask !== 8'h00) begin bad++; $display("FAIL wrdrain_end got=%b/%h exp=1/00", cap_done, o_occ_mask); end
    endtask

    task automatic test_reset_mid_out();
        do_reset();
        do_write(3'd4, 16'h4444);
        do_write(3'd6, 16'h6666);
        i_rd_ready = 1'b0;
        i_drain    = 1'b1;
        step();
        i_drain    = 1'b0;
        for (int k = 0; k < 20 && o_rd_valid !== 1'b1; k++) step();
        total++; if (o_rd_valid !== 1'b1 || o_rd_ch !== 3'd4 || o_rd_data !== 16'h4444) begin bad++; $display("FAIL rstmid_out got=v%b c%0d d%h exp=v1 c4 d4444", o_rd_valid, o_rd_ch, o_rd_data); end
        #3;
        i_rst = 1'b1;
        #1;
        total++; if (o_rd_valid !== 1'b0 || o_rd_data !== 16'h0000 || o_rd_ch !== 3'd0) begin bad++; $display("FAIL rstmid_rd got=v%b c%0d d%h exp=v0 c0 d0000", o_rd_valid, o_rd_ch, o_rd_data); end
        total++; if (o_occ_mask !== 8'h00 || o_done !== 1'b0 || o_overwrite !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%h/%b/%b exp=00/0/0", o_occ_mask, o_done, o_overwrite); end
        #2;
        i_rst = 1'b0;
        step();
        total++; if (o_wr_ready !== 1'b1 || o_occ_mask !== 8'h00) begin bad++; $display("FAIL rstmid_release got=%b/%h exp=1/00", o_wr_ready, o_occ_mask); end
        i_rd_ready = 1'b1;
        drain_collect(1'b0, 3'd0, 16'h0000);
        total++; if (cap_n !== 0 || cap_cyc !== 9) begin bad++; $display("FAIL rstmid_empty got=%0d@%0d exp=0@9", cap_n, cap_cyc); end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_sel   = '0;
        i_wr_data  = '0;
        i_drain    = 1'b0;
        i_rd_ready = 1'b0;
        test_reset();
        test_basic_drain();
        test_overwrite();
        test_stall();
        test_empty_drain();
        test_write_with_drain();
        test_reset_mid_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
